// File: rtl/keyboard_pkg.sv
// Shared constants for the music keyboard front end: key count, debounce timing
// and the active-low key level encoding used by the tone generator.
package keyboard_pkg;

  localparam int N_KEYS          = 4;
  localparam int CLK_HZ          = 50_000_000;
  localparam int DEBOUNCE_MS     = 10;
  localparam int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  // Width of a key index; never collapses to zero bits for a single key.
  function automatic int idx_width(input int n_keys);
    return (n_keys > 1) ? $clog2(n_keys) : 1;
  endfunction

endpackage : keyboard_pkg

// File: rtl/key_debouncer_if.sv
// Key bundle between the raw button pins and the tone generator: raw active-low
// inputs in, debounced levels, event pulses and the priority key index out.
interface key_debouncer_if
  import keyboard_pkg::idx_width;
#(
  parameter int N_KEYS = keyboard_pkg::N_KEYS
);

  localparam int IDX_W = idx_width(N_KEYS);

  logic [N_KEYS-1:0] i_key_raw;
  logic [N_KEYS-1:0] o_k;
  logic [N_KEYS-1:0] o_press;
  logic [N_KEYS-1:0] o_release;
  logic              o_key_valid;
  logic [IDX_W-1:0]  o_key_idx;

  // Button side: drives the pins and observes the conditioned result.
  modport master (
    output i_key_raw,
    input  o_k, o_press, o_release, o_key_valid, o_key_idx
  );

  // Debouncer side.
  modport slave (
    input  i_key_raw,
    output o_k, o_press, o_release, o_key_valid, o_key_idx
  );

endinterface : key_debouncer_if

// File: rtl/debounce_channel.sv
// One key channel: 2-flop synchroniser, stable-input counter, debounced level flop
// and registered press/release pulses aligned with the new level.
module debounce_channel
  import keyboard_pkg::KEY_PRESSED, keyboard_pkg::KEY_RELEASED;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_raw,
  output logic o_k,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_k;
  logic             r_press;
  logic             r_release;
  logic [CNT_W-1:0] r_cnt;

  logic w_differs;
  logic w_accept;

  assign w_differs = (r_sync2 != r_k);
  assign w_accept  = w_differs && (r_cnt == CNT_MAX);

  // NOTE: every flop here uses <= so all of them sample the pre-edge values;
  // blocking assignments would let r_sync2 see this cycle's r_sync1 and collapse the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= KEY_RELEASED;
      r_sync2   <= KEY_RELEASED;
      r_k       <= KEY_RELEASED;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_key_raw;
      r_sync2   <= r_sync1;
      r_press   <= w_accept && (r_sync2 == KEY_PRESSED);
      r_release <= w_accept && (r_sync2 == KEY_RELEASED);
      if (!w_differs || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_k <= r_sync2;
      end
    end
  end

  assign o_k       = r_k;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule : debounce_channel

// File: rtl/key_debouncer.sv
// Four-channel push-button conditioner feeding the tone generator's k0..k3, plus
// a lowest-index-first encoder of the currently pressed key.
module key_debouncer
  import keyboard_pkg::KEY_PRESSED, keyboard_pkg::idx_width;
#(
  parameter int N_KEYS          = keyboard_pkg::N_KEYS,
  parameter int DEBOUNCE_CYCLES = keyboard_pkg::DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  key_debouncer_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int IDX_W = idx_width(N_KEYS);

  logic [N_KEYS-1:0] w_k;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_release;
  logic              w_key_valid;
  logic [IDX_W-1:0]  w_key_idx;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (reset),
      .i_key_raw (bus.i_key_raw[g]),
      .o_k       (w_k[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g])
    );
  end

  // Scan from the top down so the lowest pressed index is written last and wins,
  // matching the tone generator's own priority.
  always_comb begin
    w_key_valid = 1'b0;
    w_key_idx   = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (w_k[i] == KEY_PRESSED) begin
        w_key_valid = 1'b1;
        w_key_idx   = IDX_W'(i);
      end
    end
  end

  assign bus.o_k         = w_k;
  assign bus.o_press     = w_press;
  assign bus.o_release   = w_release;
  assign bus.o_key_valid = w_key_valid;
  assign bus.o_key_idx   = w_key_idx;

endmodule : key_debouncer

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with a 4-cycle debounce window: a held raw level
// reaches k on the 6th rising edge counting the edge that first samples it.
module tb_key_debouncer;

  localparam int N_KEYS = 4;
  localparam int DEB    = 4;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  key_debouncer_if #(.N_KEYS(N_KEYS)) bus ();

  key_debouncer #(
    .N_KEYS          (N_KEYS),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] k_exp, input logic [3:0] p_exp,
                            input logic [3:0] r_exp, input logic v_exp, input logic [1:0] i_exp);
    check({tag, ".k"},       {4'h0, bus.o_k},         {4'h0, k_exp});
    check({tag, ".press"},   {4'h0, bus.o_press},     {4'h0, p_exp});
    check({tag, ".release"}, {4'h0, bus.o_release},   {4'h0, r_exp});
    check({tag, ".valid"},   {7'h0, bus.o_key_valid}, {7'h0, v_exp});
    check({tag, ".idx"},     {6'h0, bus.o_key_idx},   {6'h0, i_exp});
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n edges during which k must hold k_exp and no pulse may appear.
  task automatic hold(input string tag, input int n, input logic [3:0] k_exp);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, ".k"},       {4'h0, bus.o_k},       {4'h0, k_exp});
      check({tag, ".press"},   {4'h0, bus.o_press},   8'h00);
      check({tag, ".release"}, {4'h0, bus.o_release}, 8'h00);
    end
  endtask

  initial begin
    // Reset with no clock edge yet, then held across several edges.
    reset         = 1'b1;
    bus.i_key_raw = 4'b0000;
    #2 reset = 1'b0;
    #1 check_outs("rst_noclk", 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);
    hold("rst_hold", 3, 4'b1111);
    check_outs("rst_hold_end", 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);
    bus.i_key_raw = 4'b1111;
    hold("rst_flush", 2, 4'b1111);
    reset = 1'b1;
    hold("idle", 4, 4'b1111);

    // Clean press of key 2.
    bus.i_key_raw = 4'b1011;
    hold("press2_wait", 5, 4'b1111);
    tick();
    check_outs("press2_edge", 4'b1011, 4'b0100, 4'b0000, 1'b1, 2'd2);
    tick();
    check_outs("press2_after", 4'b1011, 4'b0000, 4'b0000, 1'b1, 2'd2);

    // Asynchronous reset mid-cycle, key released while in reset: no release pulse.
    #2 reset = 1'b0;
    #1 check_outs("async_rst", 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);
    bus.i_key_raw = 4'b1111;
    hold("rel_in_rst", 2, 4'b1111);
    reset = 1'b1;
    hold("post_rst", 8, 4'b1111);

    // Bounce on key 0: low 3, high 1, low 2, high 1, then low held.
    bus.i_key_raw = 4'b1110;
    hold("bounce_a", 3, 4'b1111);
    bus.i_key_raw = 4'b1111;
    hold("bounce_b", 1, 4'b1111);
    bus.i_key_raw = 4'b1110;
    hold("bounce_c", 2, 4'b1111);
    bus.i_key_raw = 4'b1111;
    hold("bounce_d", 1, 4'b1111);
    bus.i_key_raw = 4'b1110;
    hold("bounce_final", 5, 4'b1111);
    tick();
    check_outs("bounce_edge", 4'b1110, 4'b0001, 4'b0000, 1'b1, 2'd0);
    tick();
    check_outs("bounce_after", 4'b1110, 4'b0000, 4'b0000, 1'b1, 2'd0);
    bus.i_key_raw = 4'b1111;
    hold("rel0_wait", 5, 4'b1110);
    tick();
    check_outs("rel0_edge", 4'b1111, 4'b0000, 4'b0001, 1'b0, 2'd0);

    // Simultaneous press of keys 1 and 3, then release of key 1 only.
    bus.i_key_raw = 4'b0101;
    hold("simul_wait", 5, 4'b1111);
    tick();
    check_outs("simul_edge", 4'b0101, 4'b1010, 4'b0000, 1'b1, 2'd1);
    tick();
    check_outs("simul_after", 4'b0101, 4'b0000, 4'b0000, 1'b1, 2'd1);
    bus.i_key_raw = 4'b0111;
    hold("rel1_wait", 5, 4'b0101);
    tick();
    check_outs("rel1_edge", 4'b0111, 4'b0000, 4'b0010, 1'b1, 2'd3);
    tick();
    check_outs("rel1_after", 4'b0111, 4'b0000, 4'b0000, 1'b1, 2'd3);
    bus.i_key_raw = 4'b1111;
    hold("rel3_wait", 5, 4'b0111);
    tick();
    check_outs("rel3_edge", 4'b1111, 4'b0000, 4'b1000, 1'b0, 2'd0);

    // Reset with key 3's counter at 2, key held through deassertion.
    tick();
    bus.i_key_raw = 4'b0111;
    hold("midcnt_wait", 4, 4'b1111);
    #2 reset = 1'b0;
    #1 check_outs("midcnt_rst", 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);
    hold("midcnt_inrst", 2, 4'b1111);
    reset = 1'b1;
    hold("fresh_wait", 5, 4'b1111);
    tick();
    check_outs("fresh_edge", 4'b0111, 4'b1000, 4'b0000, 1'b1, 2'd3);
    tick();
    check_outs("fresh_after", 4'b0111, 4'b0000, 4'b0000, 1'b1, 2'd3);
    bus.i_key_raw = 4'b1111;
    hold("fresh_rel_wait", 5, 4'b0111);
    tick();
    check_outs("fresh_rel_edge", 4'b1111, 4'b0000, 4'b1000, 1'b0, 2'd0);

    // Single-cycle glitch on key 1 must be ignored.
    tick();
    bus.i_key_raw = 4'b1101;
    hold("glitch_lo", 1, 4'b1111);
    bus.i_key_raw = 4'b1111;
    hold("glitch_quiet", 20, 4'b1111);
    check_outs("glitch_end", 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_key_debouncer
